btn_debouncer_array: RTL and testbench
======================================

// Module: btn_debouncer_array
// PURPOSE
//   Parametrised, multi-channel successor to the single-button debouncer, sitting between raw board pins and user logic.
//   Each channel: 2-FF synchroniser, configurable pin polarity, debounce counter in both directions, press/release one-cycle pulses.
//   Each channel also has a long-press/auto-repeat pulse for menu-style UIs.
//   All channels are independent and share one clock and reset.
// PARAMETERS
//   N_BTN           4       number of channels (>=1)
//   ACTIVE_LOW      1       1: pin low = pressed; 0: pin high = pressed
//   DEBOUNCE_CYCLES 65535   cycles raw level must differ from stable state before it is accepted (>=1)
//   HOLD_CYCLES     0       cycles after press pulse to first btn_hold pulse; 0 disables hold/repeat
//   REPEAT_CYCLES   0       period of repeated btn_hold pulses after the first; 0 = single hold pulse
// PORTS
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous active-low reset
//   btn_in       in   N_BTN  raw asynchronous button pins
//   btn_state    out  N_BTN  debounced level, 1 = pressed (polarity already normalised)
//   btn_press    out  N_BTN  1-cycle pulse when btn_state rises
//   btn_release  out  N_BTN  1-cycle pulse when btn_state falls
//   btn_hold     out  N_BTN  1-cycle long-press / auto-repeat pulse
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - Synchroniser flops are loaded with the released pin level (1 if ACTIVE_LOW).
//   - All counters, btn_state, btn_press, btn_release and btn_hold are 0.
//   raw[i] = synchronised btn_in[i] XOR ACTIVE_LOW. It lags the pin by 2 clk.
//   Debounce counter (width $clog2(DEBOUNCE_CYCLES+1), per channel):
//   - raw == btn_state: counter cleared to 0.
//   - raw != btn_state and counter < DEBOUNCE_CYCLES-1: counter increments.
//   - raw != btn_state and counter == DEBOUNCE_CYCLES-1: on the next edge btn_state toggles and counter clears.
//     The matching btn_press/btn_release is 1 for exactly that cycle.
//   - Net result: stable accepted after DEBOUNCE_CYCLES consecutive mismatching cycles.
//     Pin-to-btn_state latency = 2 + DEBOUNCE_CYCLES clk.
//   - Any single cycle of raw == btn_state restarts the count (glitch rejection). Counter never wraps.
//   - btn_press and btn_release are never 1 together on one channel, and never 1 on back-to-back cycles.
//   Per-channel hold FSM (states IDLE, WAIT_HOLD, REPEAT), only when HOLD_CYCLES>0:
//   - IDLE -> WAIT_HOLD on the press pulse; hold counter is cleared.
//   - WAIT_HOLD: counts while btn_state=1.
//     btn_hold pulses on the cycle exactly HOLD_CYCLES after the btn_press cycle.
//     Then -> REPEAT if REPEAT_CYCLES>0, else -> IDLE after the single pulse, with no further pulses until release+press.
//   - REPEAT: btn_hold pulses every REPEAT_CYCLES cycles while btn_state=1.
//   - Any state -> IDLE in the cycle btn_release pulses. A hold pulse due in that same cycle is suppressed.
//   - HOLD_CYCLES==0: btn_hold is tied 0 and the FSM and counters are optimised away.
//   - Hold counter width: $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1). Saturating, no wrap.
//   Simultaneous events on different channels are fully independent; no arbitration.
//   Reset mid-debounce or mid-hold discards all progress. A button held through reset is re-detected:
//   press pulse arrives 2 + DEBOUNCE_CYCLES cycles after rst_n deasserts.
//   All outputs are registered; no combinational path from btn_in to any output.
// TESTING (N_BTN=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3)
//   1. Reset, pins high -> all outputs 0.
//      btn_in[0] low at cycle 0 and held -> btn_press[0]=1 at cycle 6 only; btn_state[0]=1 from cycle 6.
//   2. btn_in[1] bounces (low 3 cycles, high 1, low 3, high) -> no btn_press[1]; btn_state[1] stays 0.
//   3. Ch0 pressed (press pulse at cycle P), held -> btn_hold[0] at P+10, P+13, P+16...
//      Pin released -> btn_release[0] 6 cycles later; hold pulses stop.
//   4. Ch2 and ch3 pins fall in the same cycle; ch3 releases 2 cycles later ->
//      btn_press[2] at +6; no ch3 pulses; ch3 counter cleared.
//   5. Release timed so the release pulse coincides with a due hold pulse ->
//      btn_release=1, btn_hold=0 in that cycle.
//   6. Pin held low, rst_n pulsed low mid-hold -> outputs 0 immediately;
//      btn_press re-fires 6 cycles after rst_n rises.
//      Repeat with ACTIVE_LOW=0 and inverted stimulus -> identical responses.

Source files
------------

// File: rtl/btn_debouncer_array.sv
// Multi-channel push-button conditioner: per-pin synchroniser, polarity normalisation,
// symmetric debounce with press/release pulses, and an optional long-press/auto-repeat pulse.
module btn_debouncer_array #(
    parameter int N_BTN           = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 65535,
    parameter int HOLD_CYCLES     = 0,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_state,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HC_W     = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic            REL_LVL   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [DB_W-1:0] DB_ZERO   = {DB_W{1'b0}};
    localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HC_W-1:0] HC_ZERO   = {HC_W{1'b0}};
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [HC_W-1:0] REP_LAST  = HC_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HOLD = 2'd1,
        REPEAT    = 2'd2
    } hold_state_t;

    function automatic logic [HC_W-1:0] sat_inc(input logic [HC_W-1:0] cnt);
        logic [HC_W-1:0] res;
        if (cnt == {HC_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + HC_W'(1);
        end
        return res;
    endfunction

    logic [N_BTN-1:0] sync1_r;
    logic [N_BTN-1:0] sync2_r;
    logic [N_BTN-1:0] raw_s;

    // Two-flop synchroniser, parked at the released pin level during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {N_BTN{REL_LVL}};
            sync2_r <= {N_BTN{REL_LVL}};
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
        end
    end

    assign raw_s = sync2_r ^ {N_BTN{REL_LVL}};

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [DB_W-1:0] db_cnt_r;
        logic            state_r;
        logic            press_r;
        logic            release_r;
        logic            toggle_s;
        logic            rise_s;
        logic            fall_s;

        // Accept a new level only after a full run of mismatches; never right after a pulse.
        always_comb begin
            toggle_s = 1'b0;
            rise_s   = 1'b0;
            fall_s   = 1'b0;
            if ((raw_s[i] != state_r) && (db_cnt_r == DB_LAST) && !(press_r || release_r)) begin
                toggle_s = 1'b1;
                rise_s   = ~state_r;
                fall_s   = state_r;
            end else begin
                toggle_s = 1'b0;
            end
        end

        // Debounce counter, stable level and edge pulses.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt_r  <= DB_ZERO;
                state_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                press_r   <= rise_s;
                release_r <= fall_s;
                if (toggle_s) begin
                    state_r  <= ~state_r;
                    db_cnt_r <= DB_ZERO;
                end else if (raw_s[i] == state_r) begin
                    db_cnt_r <= DB_ZERO;
                end else if (db_cnt_r != DB_LAST) begin
                    db_cnt_r <= db_cnt_r + DB_ONE;
                end
            end
        end

        assign btn_state[i]   = state_r;
        assign btn_press[i]   = press_r;
        assign btn_release[i] = release_r;

        if (HOLD_CYCLES > 0) begin : g_hold
            hold_state_t     fsm_r;
            logic [HC_W-1:0] hcnt_r;
            logic            hold_r;

            // Long-press / auto-repeat sequencer; a release edge wins over a due hold pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fsm_r  <= IDLE;
                    hcnt_r <= HC_ZERO;
                    hold_r <= 1'b0;
                end else begin
                    hold_r <= 1'b0;
                    if (fall_s) begin
                        fsm_r  <= IDLE;
                        hcnt_r <= HC_ZERO;
                    end else begin
                        case (fsm_r)
                            IDLE: begin
                                if (rise_s) begin
                                    fsm_r  <= WAIT_HOLD;
                                    hcnt_r <= HC_ZERO;
                                end
                            end
                            WAIT_HOLD: begin
                                if (hcnt_r == HOLD_LAST) begin
                                    hold_r <= 1'b1;
                                    hcnt_r <= HC_ZERO;
                                    fsm_r  <= (REPEAT_CYCLES > 0) ? REPEAT : IDLE;
                                end else begin
                                    hcnt_r <= sat_inc(hcnt_r);
                                end
                            end
                            REPEAT: begin
                                if (hcnt_r == REP_LAST) begin
                                    hold_r <= 1'b1;
                                    hcnt_r <= HC_ZERO;
                                end else begin
                                    hcnt_r <= sat_inc(hcnt_r);
                                end
                            end
                            default: begin
                                fsm_r  <= IDLE;
                                hcnt_r <= HC_ZERO;
                            end
                        endcase
                    end
                end
            end

            assign btn_hold[i] = hold_r;
        end else begin : g_no_hold
            assign btn_hold[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_btn_debouncer_array.sv
// Bench for btn_debouncer_array: directed scenarios plus random bouncing pins, with an
// active-low and an active-high instance driven by mirrored pins against one reference model.
module tb_btn_debouncer_array;

    localparam int N  = 4;
    localparam int DC = 4;
    localparam int HC = 10;
    localparam int RC = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] press_lvl = 4'b0000;
    logic [N-1:0] st_a, pr_a, rl_a, hd_a;
    logic [N-1:0] st_b, pr_b, rl_b, hd_b;

    btn_debouncer_array #(.N_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DC),
                          .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)) dut_al (
        .clk(clk), .rst_n(rst_n), .btn_in(~press_lvl),
        .btn_state(st_a), .btn_press(pr_a), .btn_release(rl_a), .btn_hold(hd_a));

    btn_debouncer_array #(.N_BTN(N), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(DC),
                          .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)) dut_ah (
        .clk(clk), .rst_n(rst_n), .btn_in(press_lvl),
        .btn_state(st_b), .btn_press(pr_b), .btn_release(rl_b), .btn_hold(hd_b));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    logic [N-1:0] d1, d2;
    logic [N-1:0] m_st, m_pr, m_rl, m_hd;
    int           run   [N];
    int           pc    [N];
    bit           armed [N];

    task automatic check_eq(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        d1 = '0; d2 = '0;
        m_st = '0; m_pr = '0; m_rl = '0; m_hd = '0;
        for (int i = 0; i < N; i++) begin
            run[i] = 0; pc[i] = 0; armed[i] = 1'b0;
        end
    endtask

    // One clock edge: pressed level seen two edges ago is judged against the stable state.
    task automatic model_edge();
        logic [N-1:0] raw;
        int age;
        raw = d2; d2 = d1; d1 = press_lvl;
        m_pr = '0; m_rl = '0; m_hd = '0;
        for (int i = 0; i < N; i++) begin
            if (raw[i] == m_st[i]) begin
                run[i] = 0;
            end else begin
                run[i]++;
                if (run[i] == DC) begin
                    run[i] = 0;
                    m_st[i] = ~m_st[i];
                    if (m_st[i]) m_pr[i] = 1'b1;
                    else         m_rl[i] = 1'b1;
                end
            end
            if (m_pr[i]) begin armed[i] = 1'b1; pc[i] = cyc; end
            if (m_rl[i]) armed[i] = 1'b0;
            if (armed[i] && m_st[i]) begin
                age = cyc - pc[i];
                if (age == HC || (RC > 0 && age > HC && ((age - HC) % RC) == 0))
                    m_hd[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("state_al",   st_a, m_st);
        check_eq("press_al",   pr_a, m_pr);
        check_eq("release_al", rl_a, m_rl);
        check_eq("hold_al",    hd_a, m_hd);
        check_eq("state_ah",   st_b, m_st);
        check_eq("press_ah",   pr_b, m_pr);
        check_eq("release_ah", rl_b, m_rl);
        check_eq("hold_ah",    hd_b, m_hd);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (rst_n) model_edge();
        else       model_reset();
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Asynchronous assertion mid-cycle, synchronous release just after an edge.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        steps(n);
        rst_n = 1'b1;
    endtask

    logic [N-1:0] target;
    int           bounce [N];

    initial begin
        model_reset();
        steps(3);
        rst_n = 1'b1;
        steps(3);

        // single press on ch0
        press_lvl[0] = 1'b1;
        steps(12);
        // ch1 bouncing never accepted
        press_lvl[1] = 1'b1; steps(3);
        press_lvl[1] = 1'b0; steps(1);
        press_lvl[1] = 1'b1; steps(3);
        press_lvl[1] = 1'b0; steps(10);
        // ch0 long hold then release
        steps(15);
        press_lvl[0] = 1'b0;
        steps(10);
        // ch2/ch3 together, ch3 lets go early
        press_lvl[2] = 1'b1; press_lvl[3] = 1'b1;
        steps(2);
        press_lvl[3] = 1'b0;
        steps(4);
        // release of ch2 lands exactly on a due hold pulse
        for (int k = 0; k < 40 && cyc != pc[2] + HC; k++) step();
        press_lvl[2] = 1'b0;
        steps(6);
        check_eq("rel_hold_coincide", {2'b00, rl_a[2], hd_a[2]}, 4'b0010);
        steps(4);
        // reset mid-hold with ch1 held through it
        press_lvl[1] = 1'b1;
        steps(20);
        do_reset(2);
        steps(20);
        press_lvl[1] = 1'b0;
        steps(10);

        // random pins with bounce bursts and occasional resets
        target = press_lvl;
        for (int i = 0; i < N; i++) bounce[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 39) == 0) begin
                    target[i] = ~target[i];
                    bounce[i] = $urandom_range(0, 6);
                end
                if (bounce[i] > 0) begin
                    press_lvl[i] = 1'($urandom_range(0, 1));
                    bounce[i]--;
                end else begin
                    press_lvl[i] = target[i];
                end
            end
            if ($urandom_range(0, 599) == 0) do_reset($urandom_range(0, 2));
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
